ibex_branch_predict_bht: RTL and testbench
==========================================

Name: ibex_branch_predict_bht

Overview:
- Dynamic successor to the static fetch-stage predictor in the IF stage.
- Decodes the fetched word (RV32 and compressed) for JAL/C.J/C.JAL and BRANCH/C.BEQZ/C.BNEZ, computes target = fetch PC + immediate.
- Predicts conditional branches from a parametrised table of saturating counters, trained by the ID/EX stage on branch resolution.
- Entries never trained since reset/flush fall back to static backward-taken/forward-not-taken (BTFN).

Parameters:
- BhtEntries, 64, number of table entries; power of two, 4..1024; IdxW = clog2(BhtEntries).
- CntWidth, 2, saturating counter width, 2..4; CntMax = 2^CntWidth-1, CntMid = 2^(CntWidth-1).
- StaticFallback, 1, 1 = untrained entries use BTFN; 0 = untrained entries predict not-taken.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset
- fetch_rdata_i  input  32  instruction word at fetch PC (compressed in [15:0])
- fetch_pc_i  input  32  fetch PC
- fetch_valid_i  input  1  fetch word valid
- predict_branch_taken_o  output  1  predict redirect
- predict_branch_pc_o  output  32  predicted target
- update_valid_i  input  1  a conditional branch resolved this cycle
- update_pc_i  input  32  PC of resolved branch
- update_taken_i  input  1  resolved direction
- flush_i  input  1  invalidate all entries (e.g. fence.i, context switch)

Behaviour:
- Interface: single clock clk_i; rst_ni asynchronous, active-low. All state resets to invalid, counters = CntMid-1 (weakly not-taken).
- State: valid[BhtEntries], cnt[BhtEntries][CntWidth]. No tags; aliasing is accepted.
- Index: fetch idx = fetch_pc_i[IdxW:1]; update idx = update_pc_i[IdxW:1] (halfword granularity for compressed).
- Decode:
  - instr_j: opcode 7'h6f.
  - instr_b: opcode 7'h63.
  - instr_cj: [1:0]=01 and [15:13] in {001,101}.
  - instr_cb: [1:0]=01 and [15:13] in {110,111}.
  - Immediates are standard J/B/CJ/CB sign-extended to 32 bits.
- Target: fetch_pc_i + imm, modulo 2^32. The immediate is selected with priority j > b > cj > cb; otherwise B-type.
- Prediction, combinational, zero latency:
  - predict_branch_taken_o = fetch_valid_i & (instr_j | instr_cj | cond_taken).
  - For conditional branches (instr_b | instr_cb):
    - valid[idx]=1: cond_taken = cnt[idx] MSB.
    - valid[idx]=0 and StaticFallback=1: cond_taken = imm sign bit.
    - valid[idx]=0 and StaticFallback=0: cond_taken = 0.
  - predict_branch_pc_o is always driven with the computed target, even when not predicting taken.
  - Both outputs read 0/(0+imm) semantics only through inputs; they are not registered. During reset, taken_o = fetch_valid_i & (jump | fallback).
- Update, registered on the clock edge:
  - If update_valid_i and valid[u]=1: saturating increment if taken (hold at CntMax), decrement if not-taken (hold at 0).
  - If valid[u]=0: set valid[u]=1, cnt[u] = taken ? CntMid : CntMid-1.
- Read-before-write: if fetch idx == update idx in the same cycle, the prediction uses the pre-update value.
- Flush: flush_i clears all valid bits in one cycle; counters are untouched. If flush_i and update_valid_i occur together, flush wins and the update is dropped. Prediction in the flush cycle still uses the pre-flush state.
- Reset mid-operation: asynchronous clear of all state; the pending update is lost.
- update_pc_i upper bits above IdxW and bit 0 are ignored.
- No X propagation: outputs are defined whenever inputs are known.

Test Plan:
- Reset, fetch valid B-type BEQ at pc 0x100 with imm -8 -> taken=1, target 0xF8. Same with imm +16 -> taken=0, target 0x110 (BTFN fallback).
- JAL imm +0x800 at pc 0x2000, fetch_valid_i=0 -> taken=0; then fetch_valid_i=1 -> taken=1, target 0x2800. C.J imm -4 at 0x2002 -> target 0x1FFE.
- Forward BEQ at 0x100: train with update_taken=1 twice -> cnt 2 then 3, predict taken=1. Train not-taken once -> cnt 2, still taken. Twice more -> cnt 0, taken=0, saturates at 0 on further not-taken.
- Same-cycle fetch and update at idx of 0x100 (entry invalid, update taken) -> this-cycle prediction uses fallback; next cycle uses cnt=CntMid.
- Train entry to taken, then assert flush_i together with update_valid_i -> next cycle the entry is invalid and BTFN applies. The dropped update is confirmed by retraining once to reach CntMid.
- Aliasing with BhtEntries=4: update pc 0x100 and 0x108 (same idx) share the counter. Assert rst_ni low mid-training -> all entries invalid on the next cycle. Wrap-around: pc 0xFFFFFFFC + imm 8 -> target 0x4.

Source files
------------

// File: rtl/ibex_branch_predict_bht.sv
// Dynamic branch predictor for the IF stage: decodes jumps/branches, computes the target and
// predicts conditional branches from a table of saturating counters trained at resolution.
module ibex_branch_predict_bht #(
    parameter int unsigned BhtEntries     = 64,
    parameter int unsigned CntWidth       = 2,
    parameter bit          StaticFallback = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] fetch_rdata_i,
    input  logic [31:0] fetch_pc_i,
    input  logic        fetch_valid_i,
    output logic        predict_branch_taken_o,
    output logic [31:0] predict_branch_pc_o,
    input  logic        update_valid_i,
    input  logic [31:0] update_pc_i,
    input  logic        update_taken_i,
    input  logic        flush_i
);

    localparam int unsigned IdxW = $clog2(BhtEntries);

    localparam logic [CntWidth-1:0] CntMax  = '1;
    localparam logic [CntWidth-1:0] CntMid  = {1'b1, {(CntWidth-1){1'b0}}};
    localparam logic [CntWidth-1:0] CntInit = {1'b0, {(CntWidth-1){1'b1}}};

    logic [BhtEntries-1:0] valid_q;
    logic [CntWidth-1:0]   cnt_q [BhtEntries];

    logic [IdxW-1:0]     fetch_idx;
    logic [IdxW-1:0]     upd_idx;
    logic [CntWidth-1:0] cnt_upd;

    logic        instr_j, instr_b, instr_cj, instr_cb;
    logic [31:0] imm_j, imm_b, imm_cj, imm_cb, imm;
    logic        cond_taken;
    logic        unused_upd_pc;

    assign fetch_idx = fetch_pc_i[IdxW:1];
    assign upd_idx   = update_pc_i[IdxW:1];

    assign unused_upd_pc = ^{update_pc_i[31:IdxW+1], update_pc_i[0]};

    assign instr_j  = fetch_rdata_i[6:0] == 7'h6f;
    assign instr_b  = fetch_rdata_i[6:0] == 7'h63;
    assign instr_cj = (fetch_rdata_i[1:0] == 2'b01) &
                      ((fetch_rdata_i[15:13] == 3'b001) | (fetch_rdata_i[15:13] == 3'b101));
    assign instr_cb = (fetch_rdata_i[1:0] == 2'b01) &
                      ((fetch_rdata_i[15:13] == 3'b110) | (fetch_rdata_i[15:13] == 3'b111));

    assign imm_j  = {{12{fetch_rdata_i[31]}}, fetch_rdata_i[19:12], fetch_rdata_i[20],
                     fetch_rdata_i[30:21], 1'b0};
    assign imm_b  = {{20{fetch_rdata_i[31]}}, fetch_rdata_i[7], fetch_rdata_i[30:25],
                     fetch_rdata_i[11:8], 1'b0};
    assign imm_cj = {{21{fetch_rdata_i[12]}}, fetch_rdata_i[8], fetch_rdata_i[10:9],
                     fetch_rdata_i[6], fetch_rdata_i[7], fetch_rdata_i[2], fetch_rdata_i[11],
                     fetch_rdata_i[5:3], 1'b0};
    assign imm_cb = {{24{fetch_rdata_i[12]}}, fetch_rdata_i[6:5], fetch_rdata_i[2],
                     fetch_rdata_i[11:10], fetch_rdata_i[4:3], 1'b0};

    always_comb begin
        imm = imm_b;
        if (instr_j) begin
            imm = imm_j;
        end else if (instr_b) begin
            imm = imm_b;
        end else if (instr_cj) begin
            imm = imm_cj;
        end else if (instr_cb) begin
            imm = imm_cb;
        end
    end

    // Untrained entries fall back to the static rule: backward taken, forward not-taken.
    always_comb begin
        cond_taken = 1'b0;
        if (instr_b | instr_cb) begin
            if (valid_q[fetch_idx]) begin
                cond_taken = cnt_q[fetch_idx][CntWidth-1];
            end else if (StaticFallback) begin
                cond_taken = imm[31];
            end
        end
    end

    assign predict_branch_taken_o = fetch_valid_i & (instr_j | instr_cj | cond_taken);
    assign predict_branch_pc_o    = fetch_pc_i + imm;

    always_comb begin
        cnt_upd = update_taken_i ? CntMid : CntInit;
        if (valid_q[upd_idx]) begin
            if (update_taken_i) begin
                cnt_upd = (cnt_q[upd_idx] == CntMax) ? CntMax : cnt_q[upd_idx] + 1'b1;
            end else begin
                cnt_upd = (cnt_q[upd_idx] == '0) ? '0 : cnt_q[upd_idx] - 1'b1;
            end
        end
    end

    // Flush only clears valid bits and takes priority over a coincident update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < BhtEntries; i++) begin
                cnt_q[i] <= CntInit;
            end
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (update_valid_i) begin
            valid_q[upd_idx] <= 1'b1;
            cnt_q[upd_idx]   <= cnt_upd;
        end
    end

endmodule

// File: tb/tb_ibex_branch_predict_bht.sv
// Self-checking bench for ibex_branch_predict_bht using a 4-entry table so that aliasing
// can be exercised; expected predictions are queued when driven and compared on output.
module tb_ibex_branch_predict_bht;

    logic        clk_i;
    logic        rst_ni;
    logic [31:0] fetch_rdata_i;
    logic [31:0] fetch_pc_i;
    logic        fetch_valid_i;
    logic        predict_branch_taken_o;
    logic [31:0] predict_branch_pc_o;
    logic        update_valid_i;
    logic [31:0] update_pc_i;
    logic        update_taken_i;
    logic        flush_i;

    typedef struct {
        string       tag;
        logic        taken;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    ibex_branch_predict_bht #(
        .BhtEntries    (4),
        .CntWidth      (2),
        .StaticFallback(1'b1)
    ) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .fetch_rdata_i         (fetch_rdata_i),
        .fetch_pc_i            (fetch_pc_i),
        .fetch_valid_i         (fetch_valid_i),
        .predict_branch_taken_o(predict_branch_taken_o),
        .predict_branch_pc_o   (predict_branch_pc_o),
        .update_valid_i        (update_valid_i),
        .update_pc_i           (update_pc_i),
        .update_taken_i        (update_taken_i),
        .flush_i               (flush_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_b(input logic [31:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'h6f};
    endfunction

    function automatic logic [31:0] enc_cj(input logic [31:0] imm, input logic [2:0] f3);
        return {16'h0, f3, imm[11], imm[4], imm[9:8], imm[10], imm[6], imm[7], imm[3:1],
                imm[5], 2'b01};
    endfunction

    function automatic logic [31:0] enc_cb(input logic [31:0] imm, input logic [2:0] f3);
        return {16'h0, f3, imm[8], imm[4:3], 3'b001, imm[7:6], imm[2:1], imm[5], 2'b01};
    endfunction

    // One cycle: drive, queue expectation, compare at negedge, then cross the update edge.
    task automatic step(input string tag, input logic fv, input logic [31:0] ins,
                        input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                        input logic ut, input logic fl, input logic et,
                        input logic [31:0] ep);
        exp_t e;
        fetch_valid_i  = fv;
        fetch_rdata_i  = ins;
        fetch_pc_i     = pc;
        update_valid_i = uv;
        update_pc_i    = upc;
        update_taken_i = ut;
        flush_i        = fl;
        exp_q.push_back('{tag: tag, taken: et, pc: ep});
        @(negedge clk_i);
        e = exp_q.pop_front();
        check_eq({e.tag, "_taken"}, {31'd0, predict_branch_taken_o}, {31'd0, e.taken});
        check_eq({e.tag, "_pc"}, predict_branch_pc_o, e.pc);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [31:0] fwd, bwd;
        checks = 0;
        errors = 0;
        rst_ni = 1'b0;
        fetch_valid_i = 1'b0;
        fetch_rdata_i = '0;
        fetch_pc_i = '0;
        update_valid_i = 1'b0;
        update_pc_i = '0;
        update_taken_i = 1'b0;
        flush_i = 1'b0;
        fwd = enc_b(32'd16);
        bwd = enc_b(-32'sd8);
        #1;

        // Static fallback, also while reset is held
        step("rst_bwd", 1, bwd, 32'h100, 1, 32'h100, 1, 0, 1, 32'hF8);
        rst_ni = 1'b1;
        step("btfn_fwd", 1, fwd, 32'h100, 0, 0, 0, 0, 0, 32'h110);
        step("jal_nv", 0, enc_j(32'h800), 32'h2000, 0, 0, 0, 0, 0, 32'h2800);
        step("jal_v", 1, enc_j(32'h800), 32'h2000, 0, 0, 0, 0, 1, 32'h2800);
        step("cj", 1, enc_cj(-32'sd4, 3'b101), 32'h2002, 0, 0, 0, 0, 1, 32'h1FFE);

        // Training on entry of 0x100; same-cycle update sees the pre-update state
        step("rbw", 1, fwd, 32'h100, 1, 32'h100, 1, 0, 0, 32'h110);
        step("cnt2", 1, fwd, 32'h100, 0, 0, 0, 0, 1, 32'h110);
        step("cnt2_t", 1, fwd, 32'h100, 1, 32'h100, 1, 0, 1, 32'h110);
        step("cnt3_nt", 1, fwd, 32'h100, 1, 32'h100, 0, 0, 1, 32'h110);
        step("cnt2_nt", 1, fwd, 32'h100, 1, 32'h100, 0, 0, 1, 32'h110);
        step("cnt1_nt", 1, fwd, 32'h100, 1, 32'h100, 0, 0, 0, 32'h110);
        step("cnt0_nt", 1, fwd, 32'h100, 1, 32'h100, 0, 0, 0, 32'h110);
        step("sat0_t", 1, fwd, 32'h100, 1, 32'h100, 1, 0, 0, 32'h110);
        step("cnt1", 1, fwd, 32'h100, 0, 0, 0, 0, 0, 32'h110);

        // Flush beats a coincident update; prediction in the flush cycle is pre-flush
        step("pre_fl_t", 1, fwd, 32'h100, 1, 32'h100, 1, 0, 0, 32'h110);
        step("flush", 1, fwd, 32'h100, 1, 32'h100, 1, 1, 1, 32'h110);
        step("post_fl", 1, fwd, 32'h100, 0, 0, 0, 0, 0, 32'h110);
        step("post_fl_b", 1, bwd, 32'h100, 1, 32'h100, 1, 0, 1, 32'hF8);
        step("retrain", 1, fwd, 32'h100, 1, 32'h100, 0, 0, 1, 32'h110);
        step("retr_cnt1", 1, fwd, 32'h100, 0, 0, 0, 0, 0, 32'h110);

        // Saturation at the top
        step("up1", 1, fwd, 32'h100, 1, 32'h100, 1, 0, 0, 32'h110);
        step("up2", 1, fwd, 32'h100, 1, 32'h100, 1, 0, 1, 32'h110);
        step("up3", 1, fwd, 32'h100, 1, 32'h100, 1, 0, 1, 32'h110);
        step("sat3_nt", 1, fwd, 32'h100, 1, 32'h100, 0, 0, 1, 32'h110);
        step("cnt2b", 1, fwd, 32'h100, 0, 0, 0, 0, 1, 32'h110);

        // Aliasing; upper PC bits and bit 0 of update PC ignored; other entries untouched
        step("alias_nt", 1, fwd, 32'h100, 1, 32'h108, 0, 0, 1, 32'h110);
        step("alias_hi", 1, fwd, 32'h100, 1, 32'hFFFF_0109, 1, 0, 0, 32'h110);
        step("alias_c2", 1, fwd, 32'h100, 0, 0, 0, 0, 1, 32'h110);
        step("other_idx", 1, fwd, 32'h102, 0, 0, 0, 0, 0, 32'h112);

        // Asynchronous reset mid-training drops the pending update
        rst_ni = 1'b0;
        step("rst_mid", 1, fwd, 32'h100, 1, 32'h100, 1, 0, 0, 32'h110);
        rst_ni = 1'b1;
        step("after_rst", 1, fwd, 32'h100, 0, 0, 0, 0, 0, 32'h110);
        step("after_rst_b", 1, bwd, 32'h100, 0, 0, 0, 0, 1, 32'hF8);

        // Compressed branches, C.JAL, non-branch and target wrap-around
        step("cbeqz_bwd", 1, enc_cb(-32'sd6, 3'b110), 32'h204, 0, 0, 0, 0, 1, 32'h1FE);
        step("cbnez_fwd", 1, enc_cb(32'd10, 3'b111), 32'h206, 0, 0, 0, 0, 0, 32'h210);
        step("cjal", 1, enc_cj(32'h20, 3'b001), 32'h300, 0, 0, 0, 0, 1, 32'h320);
        step("addi", 1, 32'h0000_0013, 32'h40, 0, 0, 0, 0, 0, 32'h40);
        step("wrap", 1, enc_b(32'd8), 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
